// File: rtl/digit_cell_reader.sv
// Samples a 2x-scaled 5x5 seven-segment digit cell from a raster beam stream,
// decodes it once per frame and tracks how long the decoded digit stays unchanged.
module digit_cell_reader #(
    parameter int X0            = 16,
    parameter int Y0            = 0,
    parameter int STABLE_FRAMES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       display_on,
    input  logic [8:0] hpos,
    input  logic [8:0] vpos,
    input  logic       pixel,
    output logic [6:0] seg_mask,
    output logic [3:0] digit,
    output logic       valid,
    output logic       error,
    output logic [3:0] stable_digit,
    output logic       stable_valid
);

    localparam logic [8:0] COL0_C    = 9'(X0);
    localparam logic [8:0] COL2_C    = 9'(X0 + 4);
    localparam logic [8:0] COL4_C    = 9'(X0 + 8);
    localparam logic [8:0] ROW0_C    = 9'(Y0);
    localparam logic [8:0] ROW1_C    = 9'(Y0 + 2);
    localparam logic [8:0] ROW2_C    = 9'(Y0 + 4);
    localparam logic [8:0] ROW3_C    = 9'(Y0 + 6);
    localparam logic [8:0] ROW4_C    = 9'(Y0 + 8);
    localparam logic [8:0] END_ROW_C = 9'(Y0 + 10);
    localparam logic [3:0] SF_C      = 4'(STABLE_FRAMES);

    typedef enum logic [1:0] {
        WAIT_TOP = 2'd0,
        CAPTURE  = 2'd1,
        DECODE   = 2'd2
    } state_t;

    // Seven-segment pattern to digit; anything unrecognised maps to 4'hF.
    function automatic logic [3:0] decode_digit(input logic [6:0] m);
        logic [3:0] d;
        case (m)
            7'b1111110: d = 4'd0;
            7'b0110000: d = 4'd1;
            7'b1101101: d = 4'd2;
            7'b1111001: d = 4'd3;
            7'b0110011: d = 4'd4;
            7'b1011011: d = 4'd5;
            7'b1011111: d = 4'd6;
            7'b1110000: d = 4'd7;
            7'b1111111: d = 4'd8;
            7'b1111011: d = 4'd9;
            default:    d = 4'hF;
        endcase
        return d;
    endfunction

    state_t     state_r, state_next_s;
    logic [6:0] acc_r, acc_next_s, acc_upd_s, hit_s;
    logic [3:0] cnt_r, cnt_next_s;
    logic [3:0] dec_digit_s;
    logic       dec_err_s, reach_s;
    logic       sample_s, top_s, end_s, abort_s;

    logic [6:0] seg_mask_r;
    logic [3:0] digit_r, stable_digit_r;
    logic       valid_r, error_r, stable_valid_r;

    assign sample_s = pixel & display_on;
    assign top_s    = (hpos == 9'd0) && (vpos == ROW0_C);
    assign end_s    = (hpos == 9'd0) && (vpos == END_ROW_C);
    assign abort_s  = (vpos < ROW0_C);

    // Which accumulator bit, if any, the beam position selects this cycle.
    always_comb begin
        hit_s    = 7'b0000000;
        hit_s[6] = (vpos == ROW0_C) && (hpos == COL2_C);
        hit_s[1] = (vpos == ROW1_C) && (hpos == COL0_C);
        hit_s[5] = (vpos == ROW1_C) && (hpos == COL4_C);
        hit_s[0] = (vpos == ROW2_C) && (hpos == COL2_C);
        hit_s[2] = (vpos == ROW3_C) && (hpos == COL0_C);
        hit_s[4] = (vpos == ROW3_C) && (hpos == COL4_C);
        hit_s[3] = (vpos == ROW4_C) && (hpos == COL2_C);
        acc_upd_s = (acc_r & ~hit_s) | ({7{sample_s}} & hit_s);
    end

    // Capture state machine: next state and accumulator contents.
    always_comb begin
        state_next_s = state_r;
        acc_next_s   = acc_r;
        case (state_r)
            WAIT_TOP: begin
                if (top_s) begin
                    state_next_s = CAPTURE;
                    acc_next_s   = 7'b0000000;
                end else begin
                    state_next_s = WAIT_TOP;
                end
            end
            CAPTURE: begin
                // End marker wins over everything; a fresh top marker re-arms.
                if (end_s) begin
                    state_next_s = DECODE;
                end else if (abort_s) begin
                    state_next_s = WAIT_TOP;
                end else if (top_s) begin
                    acc_next_s = 7'b0000000;
                end else begin
                    acc_next_s = acc_upd_s;
                end
            end
            DECODE: begin
                state_next_s = WAIT_TOP;
            end
            default: begin
                state_next_s = WAIT_TOP;
                acc_next_s   = 7'b0000000;
            end
        endcase
    end

    // State and accumulator registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= WAIT_TOP;
            acc_r   <= 7'b0000000;
        end else begin
            state_r <= state_next_s;
            acc_r   <= acc_next_s;
        end
    end

    // Decode result and next stability count for the DECODE cycle.
    always_comb begin
        dec_digit_s = decode_digit(acc_r);
        dec_err_s   = (dec_digit_s == 4'hF);
        cnt_next_s  = 4'd0;
        if (dec_err_s) begin
            cnt_next_s = 4'd0;
        end else if (dec_digit_s == digit_r) begin
            cnt_next_s = (cnt_r >= SF_C) ? SF_C : cnt_r + 4'd1;
        end else begin
            cnt_next_s = 4'd1;
        end
        reach_s = !dec_err_s && (cnt_next_s == SF_C);
    end

    // Output and stability registers, updated on the DECODE cycle only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg_mask_r     <= 7'b0000000;
            digit_r        <= 4'hF;
            valid_r        <= 1'b0;
            error_r        <= 1'b0;
            cnt_r          <= 4'd0;
            stable_digit_r <= 4'hF;
            stable_valid_r <= 1'b0;
        end else begin
            valid_r <= (state_r == DECODE);
            if (state_r == DECODE) begin
                seg_mask_r     <= acc_r;
                digit_r        <= dec_digit_s;
                error_r        <= dec_err_s;
                cnt_r          <= cnt_next_s;
                stable_valid_r <= reach_s;
                if (reach_s) begin
                    stable_digit_r <= dec_digit_s;
                end
            end
        end
    end

    assign seg_mask     = seg_mask_r;
    assign digit        = digit_r;
    assign valid        = valid_r;
    assign error        = error_r;
    assign stable_digit = stable_digit_r;
    assign stable_valid = stable_valid_r;

endmodule

// File: tb/tb_digit_cell_reader.sv
// Directed bench for digit_cell_reader: renders seven-segment cells on a
// small raster scan and compares decode results against hand-computed values.
module tb_digit_cell_reader;

    localparam int X0     = 16;
    localparam int Y0     = 0;
    localparam int H_LAST = 39;
    localparam int V_LAST = 13;

    logic       clk = 1'b0;
    logic       reset;
    logic       display_on;
    logic [8:0] hpos;
    logic [8:0] vpos;
    logic       pixel;
    logic [6:0] seg_mask;
    logic [3:0] digit;
    logic       valid;
    logic       error;
    logic [3:0] stable_digit;
    logic       stable_valid;

    digit_cell_reader #(.X0(X0), .Y0(Y0), .STABLE_FRAMES(2)) dut (
        .clk(clk), .reset(reset), .display_on(display_on), .hpos(hpos),
        .vpos(vpos), .pixel(pixel), .seg_mask(seg_mask), .digit(digit),
        .valid(valid), .error(error), .stable_digit(stable_digit),
        .stable_valid(stable_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Snapshot of the outputs on every valid cycle.
    int         vcount = 0;
    int         vcyc   = -1;
    logic [6:0] m_mask;
    logic [3:0] m_dig, m_sdig;
    logic       m_err, m_sval;
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            vcount = vcount + 1;
            vcyc   = cyc;
            m_mask = seg_mask;
            m_dig  = digit;
            m_err  = error;
            m_sdig = stable_digit;
            m_sval = stable_valid;
        end
    end

    int tests = 0;
    int fails = 0;
    int t_end = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic lit(input logic [6:0] m, input int h, input int v);
        logic res;
        int r, c;
        res = 1'b0;
        for (int s = 0; s < 7; s++) begin
            case (s)
                6: begin r = 0; c = 2; end
                5: begin r = 1; c = 4; end
                4: begin r = 3; c = 4; end
                3: begin r = 4; c = 2; end
                2: begin r = 3; c = 0; end
                1: begin r = 1; c = 0; end
                default: begin r = 2; c = 2; end
            endcase
            if (m[s] && h >= X0 + 2*c && h <= X0 + 2*c + 1 && v >= Y0 + 2*r && v <= Y0 + 2*r + 1)
                res = 1'b1;
        end
        return res;
    endfunction

    // One raster frame; stop_v ends it early (beam wraps), rst_v pulses reset there.
    task automatic run_frame(input logic [6:0] m, input logic disp, input int stop_v, input int rst_v);
        for (int v = 0; v <= V_LAST; v++) begin
            for (int h = 0; h <= H_LAST; h++) begin
                if (v == stop_v && h == 0) return;
                if (v == rst_v && h == 0) begin
                    reset = 1'b0;
                    repeat (3) @(posedge clk);
                    #1 reset = 1'b1;
                    return;
                end
                @(posedge clk);
                #1;
                hpos       = 9'(h);
                vpos       = 9'(v);
                display_on = disp && (h < 36) && (v < 12);
                pixel      = lit(m, h, v);
                if (h == 0 && v == Y0 + 10) t_end = cyc;
            end
        end
    endtask

    task automatic frame_check(input string name, input logic [6:0] m, input logic disp,
                               input logic [6:0] e_mask, input logic [3:0] e_dig, input logic e_err);
        int n0;
        n0 = vcount;
        run_frame(m, disp, -1, -1);
        check({name, "_pulses"}, 32'(vcount - n0), 32'd1);
        check({name, "_latency"}, 32'(vcyc), 32'(t_end + 2));
        check({name, "_mask"}, 32'(m_mask), 32'(e_mask));
        check({name, "_digit"}, 32'(m_dig), 32'(e_dig));
        check({name, "_error"}, 32'(m_err), 32'(e_err));
    endtask

    typedef struct {
        logic [6:0] mask;
        logic [3:0] dig;
        logic       err;
    } vec_t;

    vec_t tbl[13];
    int   n0;

    initial begin
        tbl[0]  = '{7'b1111001, 4'd3, 1'b0};
        tbl[1]  = '{7'b1111110, 4'd0, 1'b0};
        tbl[2]  = '{7'b0110000, 4'd1, 1'b0};
        tbl[3]  = '{7'b1101101, 4'd2, 1'b0};
        tbl[4]  = '{7'b0110011, 4'd4, 1'b0};
        tbl[5]  = '{7'b1011011, 4'd5, 1'b0};
        tbl[6]  = '{7'b1011111, 4'd6, 1'b0};
        tbl[7]  = '{7'b1110000, 4'd7, 1'b0};
        tbl[8]  = '{7'b1111111, 4'd8, 1'b0};
        tbl[9]  = '{7'b1111011, 4'd9, 1'b0};
        tbl[10] = '{7'b0000001, 4'hF, 1'b1};
        tbl[11] = '{7'b1111101, 4'hF, 1'b1};
        tbl[12] = '{7'b0000000, 4'hF, 1'b1};

        reset = 1'b0; display_on = 1'b0; hpos = 9'd0; vpos = 9'd100; pixel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mask", 32'(seg_mask), 32'h0);
        check("rst_digit", 32'(digit), 32'hF);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_error", 32'(error), 32'h0);
        check("rst_sdigit", 32'(stable_digit), 32'hF);
        check("rst_svalid", 32'(stable_valid), 32'h0);
        reset = 1'b1;

        for (int i = 0; i < 13; i++)
            frame_check($sformatf("vec%0d", i), tbl[i].mask, 1'b1, tbl[i].mask, tbl[i].dig, tbl[i].err);

        // Stability: two identical frames of 8, then an error frame.
        frame_check("stab1", 7'b1111111, 1'b1, 7'b1111111, 4'd8, 1'b0);
        check("stab1_svalid", 32'(m_sval), 32'h0);
        frame_check("stab2", 7'b1111111, 1'b1, 7'b1111111, 4'd8, 1'b0);
        check("stab2_sdigit", 32'(m_sdig), 32'h8);
        check("stab2_svalid", 32'(m_sval), 32'h1);
        frame_check("stab_err", 7'b0000001, 1'b1, 7'b0000001, 4'hF, 1'b1);
        check("stab_err_sdigit", 32'(m_sdig), 32'h8);
        check("stab_err_svalid", 32'(m_sval), 32'h0);

        // Reset pulse mid-capture: no decode, state cleared, next frame reads 1.
        n0 = vcount;
        run_frame(7'b1011011, 1'b1, -1, 5);
        check("midrst_pulses", 32'(vcount - n0), 32'd0);
        check("midrst_digit", 32'(digit), 32'hF);
        check("midrst_sdigit", 32'(stable_digit), 32'hF);
        check("midrst_svalid", 32'(stable_valid), 32'h0);
        frame_check("after_rst", 7'b0110000, 1'b1, 7'b0110000, 4'd1, 1'b0);

        // Beam wraps to row 0 at row 6: only the following full frame decodes.
        n0 = vcount;
        run_frame(7'b1111111, 1'b1, 6, -1);
        check("wrap_pulses", 32'(vcount - n0), 32'd0);
        frame_check("after_wrap", 7'b1110000, 1'b1, 7'b1110000, 4'd7, 1'b0);

        // Pixels drawn but display blanked for the whole frame.
        frame_check("blank", 7'b1111111, 1'b0, 7'b0000000, 4'hF, 1'b1);

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/digit_cell_reader.md
DIGIT_CELL_READER -- requirements
Module: digit_cell_reader

Interface
REQ-001 Parameter X0, default 16: hpos of the cell's left pixel column.
REQ-002 Parameter Y0, default 0: vpos of the cell's top pixel row; Y0+10 SHALL be at most 511.
REQ-003 Parameter STABLE_FRAMES, default 2, range 1..15: the number of consecutive identical decodes needed to declare a digit stable.
REQ-004 clk  input  1  single clock; all state SHALL change on the rising edge only.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 display_on  input  1  high while the beam is in the visible area.
REQ-007 hpos  input  9  beam column, aligned with pixel in the same cycle.
REQ-008 vpos  input  9  beam row, aligned with pixel in the same cycle.
REQ-009 pixel  input  1  rendered pixel value (green channel of the digit renderer).
REQ-010 seg_mask  output  7  captured segments; bit 6 = top, 5 = upper-right, 4 = lower-right, 3 = bottom, 2 = lower-left, 1 = upper-left, 0 = middle.
REQ-011 digit  output  4  decoded digit 0..9, or 4'hF if the pattern is not a valid digit.
REQ-012 valid  output  1  one-cycle pulse when seg_mask, digit and error are updated.
REQ-013 error  output  1  high with valid when seg_mask matches no digit; held until the next update.
REQ-014 stable_digit  output  4  last digit that met the stability criterion.
REQ-015 stable_valid  output  1  high while stable_digit is current.

Function
REQ-016 Cell geometry: 5x5 bitmap, 2x scaled; bitmap cell (row r, col c) SHALL be sampled at hpos = X0+2c, vpos = Y0+2r.
REQ-017 Sample points per segment:
  - seg6 = (0,2), seg1 = (1,0), seg5 = (1,4), seg0 = (2,2)
  - seg2 = (3,0), seg4 = (3,4), seg3 = (4,2)
REQ-018 Sampled value SHALL be pixel AND display_on; a sample point never visited during CAPTURE SHALL read 0.
REQ-019 State machine states: WAIT_TOP, CAPTURE, DECODE.
REQ-020 WAIT_TOP -> CAPTURE on the cycle with hpos==0 and vpos==Y0; the segment accumulator SHALL clear on that edge.
REQ-021 CAPTURE: on each cycle matching a sample point, the corresponding accumulator bit SHALL be loaded with the sampled value.
REQ-022 CAPTURE -> DECODE on the end marker, defined as hpos==0 and vpos==Y0+10.
REQ-023 CAPTURE -> WAIT_TOP with no output update if vpos < Y0 (frame restart, abort).
REQ-024 DECODE lasts one cycle and then returns to WAIT_TOP.
REQ-025 Decode table, seg_mask -> digit:
  - 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4
  - 1011011->5, 1011111->6, 1110000->7, 1111111->8, 1111011->9
  - any other pattern -> 4'hF with error=1
REQ-026 Latency: with the end marker in cycle T, seg_mask, digit and error SHALL update and valid SHALL be high in cycle T+2 only.
REQ-027 Stability counter: 4-bit, saturating at STABLE_FRAMES.
  - It SHALL increment on a valid non-error decode equal to the previous decoded digit.
  - It SHALL load 1 on a valid non-error decode that differs from the previous one.
  - It SHALL clear on an error decode.
REQ-028 When the counter reaches STABLE_FRAMES, stable_digit SHALL take the digit and stable_valid SHALL go 1 in that same valid cycle.
REQ-029 An error decode SHALL clear stable_valid in its valid cycle; stable_digit SHALL hold its value.
REQ-030 With STABLE_FRAMES=1, every non-error decode SHALL update stable_digit immediately.
REQ-031 If the end marker and the top marker fall in the same cycle, which geometry makes impossible, the end marker SHALL take priority.

Reset
REQ-032 While reset is low, the block SHALL hold:
  - state = WAIT_TOP, accumulator = 0, counter = 0
  - seg_mask = 0, digit = 4'hF, valid = 0, error = 0
  - stable_digit = 4'hF, stable_valid = 0
REQ-033 Assertion of reset mid-CAPTURE SHALL discard the capture with no valid pulse; capture SHALL resume only at the next top marker after deassertion.

Verification
REQ-034 Render digit 3 at X0=16, Y0=0 -> in cycle T+2: seg_mask=1111001, digit=3, error=0, one-cycle valid.
REQ-035 Render 8 for two frames (STABLE_FRAMES=2) -> stable_valid=0 after frame 1; stable_digit=8 and stable_valid=1 at frame 2 valid.
REQ-036 Render segment mask 0000001 -> digit=F, error=1, stable_valid cleared, stable_digit unchanged.
REQ-037 Drive reset low at vpos=5 during CAPTURE, then release -> no valid that frame; next full frame of digit 1 -> digit=1.
REQ-038 Wrap vpos to 0 at vpos=6 during CAPTURE -> no valid pulse; the following full frame decodes normally.
REQ-039 Hold display_on=0 for a whole frame -> seg_mask=0000000, digit=F, error=1.
